// File: rtl/cpu_run_pkg.sv
// Shared types for the CPU run controller: FSM states, end-cause codes
// and the priority encoder used to pick a single termination cause.
package cpu_run_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } run_state_t;

  typedef enum logic [2:0] {
    CAUSE_NONE    = 3'd0,
    CAUSE_HALT    = 3'd1,
    CAUSE_STALL   = 3'd2,
    CAUSE_TIMEOUT = 3'd3,
    CAUSE_MBOX    = 3'd4
  } end_cause_t;

  // Highest-priority cause wins: halt > mailbox > stall > timeout.
  function automatic end_cause_t pick_cause(
    input logic i_halt,
    input logic i_mbox,
    input logic i_stall,
    input logic i_tmo
  );
    end_cause_t w_cause;
    w_cause = CAUSE_NONE;
    if (i_halt)       w_cause = CAUSE_HALT;
    else if (i_mbox)  w_cause = CAUSE_MBOX;
    else if (i_stall) w_cause = CAUSE_STALL;
    else if (i_tmo)   w_cause = CAUSE_TIMEOUT;
    return w_cause;
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous reset, clear and enable;
// holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !(&r_cnt)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for CPU bring-up: stretched core reset, run counters and
// end-of-run detection. Mailbox termination is built only with CPU_RUN_CTRL_MAILBOX_EN.
//
// state | meaning
// HOLD  | core held in reset for RST_CYCLES cycles
// RUN   | core running, counters and end detectors active
// DONE  | run ended, results frozen until rst
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int              ADDR_W       = 16,
  parameter int              CNT_W        = 32,
  parameter int              RST_CYCLES   = 4,
  parameter int              TIMEOUT      = 250,
  parameter int              STALL_CYCLES = 8,
  parameter logic [ADDR_W-1:0] MBOX_ADDR  = 16'hFFF0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_retire,
  input  logic              i_halt,
  input  logic              i_mem_we,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [7:0]        i_mem_wdata,
  output logic              o_cpu_rst,
  output logic              o_running,
  output logic              o_sim_end,
  output logic [2:0]        o_end_cause,
  output logic [7:0]        o_exit_code,
  output logic [CNT_W-1:0]  o_cycle_cnt,
  output logic [CNT_W-1:0]  o_instr_cnt
);

  localparam int HOLD_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int STALL_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;

  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'((RST_CYCLES > 0) ? RST_CYCLES - 1 : 0);
  // Counter value seen on the retire that completes the stall run.
  localparam logic [STALL_W-1:0] STALL_HIT = STALL_W'((STALL_CYCLES > 1) ? STALL_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0]   TMO_LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  run_state_t          r_state;
  run_state_t          w_state_nxt;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [STALL_W-1:0]  r_stall_cnt;
  logic [ADDR_W-1:0]   r_last_pc;
  end_cause_t          r_end_cause;
  end_cause_t          w_cause;
  logic [CNT_W-1:0]    w_cycle_cnt;
  logic [CNT_W-1:0]    w_instr_cnt;

  logic w_in_hold;
  logic w_in_run;
  logic w_same_pc;
  logic w_ev_halt;
  logic w_ev_mbox;
  logic w_ev_stall;
  logic w_ev_tmo;
  logic w_end;

  assign w_in_hold = (r_state == HOLD);
  assign w_in_run  = (r_state == RUN);
  assign w_same_pc = i_retire && (i_pc == r_last_pc);

  assign w_ev_halt  = i_halt;
  assign w_ev_stall = (STALL_CYCLES != 0) && w_same_pc &&
                      ((STALL_CYCLES == 1) || (r_stall_cnt == STALL_HIT));
  assign w_ev_tmo   = (TIMEOUT != 0) && (w_cycle_cnt == TMO_LAST);

`ifdef CPU_RUN_CTRL_MAILBOX_EN
  logic [7:0] r_exit_code;

  assign w_ev_mbox = i_mem_we && (i_mem_addr == MBOX_ADDR);

  // Exit code is captured even when a simultaneous halt takes the cause.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_exit_code <= 8'h00;
    end else if (w_in_run && w_ev_mbox) begin
      r_exit_code <= i_mem_wdata;
    end
  end

  assign o_exit_code = r_exit_code;
`else
  logic w_unused_mbox;

  assign w_ev_mbox     = 1'b0;
  assign w_unused_mbox = ^{i_mem_we, i_mem_addr, i_mem_wdata, MBOX_ADDR};
  assign o_exit_code   = 8'h00;
`endif

  assign w_end   = w_ev_halt || w_ev_mbox || w_ev_stall || w_ev_tmo;
  assign w_cause = pick_cause(w_ev_halt, w_ev_mbox, w_ev_stall, w_ev_tmo);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= HOLD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      HOLD:    if (r_hold_cnt == HOLD_LAST) w_state_nxt = RUN;
      RUN:     if (w_end) w_state_nxt = DONE;
      DONE:    w_state_nxt = DONE;
      default: w_state_nxt = HOLD;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold_cnt <= '0;
    end else if (w_in_hold && (r_hold_cnt != HOLD_LAST)) begin
      r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
      r_last_pc   <= '0;
    end else if (w_in_run && i_retire) begin
      r_last_pc   <= i_pc;
      r_stall_cnt <= w_same_pc ? r_stall_cnt + STALL_W'(1) : '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_end_cause <= CAUSE_NONE;
    end else if (w_in_run && w_end) begin
      r_end_cause <= w_cause;
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (w_in_hold),
    .i_en  (w_in_run),
    .o_cnt (w_cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (w_in_hold),
    .i_en  (w_in_run && i_retire),
    .o_cnt (w_instr_cnt)
  );

  assign o_cpu_rst   = w_in_hold;
  assign o_running   = w_in_run;
  assign o_sim_end   = (r_state == DONE);
  assign o_end_cause = r_end_cause;
  assign o_cycle_cnt = w_cycle_cnt;
  assign o_instr_cnt = w_instr_cnt;

endmodule
